fixed_point_divider_seq: RTL and testbench

//  Parametrised, multi-cycle unsigned fixed-point divider (restoring, radix-2, one quotient bit per clock).

---
 rtl/fxdiv_pkg.sv | 18 +
 rtl/fixed_point_divider_seq_if.sv | 27 ++
 rtl/fxdiv_step.sv | 19 +
 rtl/fixed_point_divider_seq.sv | 147 ++++++++++++++
 tb/tb_fixed_point_divider_seq.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fxdiv_pkg.sv
// Shared types and helpers for the sequential fixed-point divider.
package fxdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } fxdiv_state_t;

    // Quotient width: integer bits plus fractional bits.
    function automatic int qw(input int dw, input int frac);
        return dw + frac;
    endfunction

    // Fill bit for the divide-by-zero quotient (all ones).
    localparam logic DBZ_FILL = 1'b1;

endpackage

// File: rtl/fixed_point_divider_seq_if.sv
// Start/busy/done handshake and operand/result bus for fixed_point_divider_seq.
interface fixed_point_divider_seq_if #(
    parameter int DW   = 8,
    parameter int VW   = 4,
    parameter int FRAC = 4
);
    localparam int QW = fxdiv_pkg::qw(DW, FRAC);

    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [QW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/fxdiv_step.sv
// One restoring radix-2 iteration: shift in a dividend bit, compare, conditionally subtract.
module fxdiv_step #(
    parameter int VW = 4
) (
    input  logic [VW-1:0] r_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] r_out,
    output logic          qbit
);
    logic [VW:0] shifted;

    always_comb begin
        shifted = {r_in, bit_in};
        qbit    = (shifted >= {1'b0, divisor});
        // After a successful subtract the result is below divisor, so VW bits suffice.
        r_out   = qbit ? VW'(shifted - {1'b0, divisor}) : shifted[VW-1:0];
    end
endmodule

// File: rtl/fixed_point_divider_seq.sv
// Multi-cycle unsigned fixed-point divider, quotient = floor(dividend*2^FRAC/divisor).
// Define FXDIV_ROUND_EN for round-half-up via one extra guard iteration.
module fixed_point_divider_seq
    import fxdiv_pkg::*;
#(
    parameter int DW   = 8,
    parameter int VW   = 4,
    parameter int FRAC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fixed_point_divider_seq_if.slave bus
);
    localparam int QW = qw(DW, FRAC);
`ifdef FXDIV_ROUND_EN
    localparam int NITER = QW + 1;
`else
    localparam int NITER = QW;
`endif
    // Quotient bits kept in the shifter; the final bit is merged on the done edge.
    localparam int QSW = NITER - 1;
    localparam int CW  = $clog2(QW + 1);
    localparam logic [CW-1:0] LAST = CW'(NITER - 1);

    fxdiv_state_t state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [QW-1:0]  dsh;
    logic [QSW-1:0] qsh;
    logic [VW-1:0]  r;
    logic [VW-1:0]  dvs;
    logic [VW-1:0]  r_nxt;
    logic           qbit;
    logic           accept;
    logic           last;
    logic [QW-1:0]  q_final;
    logic [VW-1:0]  rem_final;
    logic [QW-1:0]  q_out;
    logic [VW-1:0]  rem_out;
    logic           dbz_out;

    assign accept = bus.start && (state != CALC);
    assign last   = (state == CALC) && (cnt == LAST);

    fxdiv_step #(.VW(VW)) u_step (
        .r_in    (r),
        .bit_in  (dsh[QW-1]),
        .divisor (dvs),
        .r_out   (r_nxt),
        .qbit    (qbit)
    );

`ifdef FXDIV_ROUND_EN
    localparam logic [CW-1:0] TRUNC_LAST = CW'(QW - 1);
    logic [VW-1:0] rem_trunc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_trunc <= '0;
        end else if (state == CALC && cnt == TRUNC_LAST) begin
            rem_trunc <= r_nxt;
        end
    end

    // qsh holds the truncated quotient; qbit is the guard bit. Saturate at all ones.
    always_comb begin
        q_final   = (&qsh) ? qsh : qsh + QW'(qbit);
        rem_final = rem_trunc;
    end
`else
    always_comb begin
        q_final   = {qsh, qbit};
        rem_final = r_nxt;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (bus.start) begin
                    state_nxt = (bus.divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dsh <= '0;
            qsh <= '0;
            r   <= '0;
            dvs <= '0;
        end else if (accept) begin
            cnt <= '0;
            dsh <= {bus.dividend, {FRAC{1'b0}}};
            qsh <= '0;
            r   <= '0;
            dvs <= bus.divisor;
        end else if (state == CALC) begin
            if (!last) begin
                cnt <= cnt + CW'(1);
            end
            dsh <= {dsh[QW-2:0], 1'b0};
            qsh <= {qsh[QSW-2:0], qbit};
            r   <= r_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_out   <= '0;
            rem_out <= '0;
            dbz_out <= 1'b0;
        end else if (accept && bus.divisor == '0) begin
            q_out   <= {QW{DBZ_FILL}};
            rem_out <= '0;
            dbz_out <= 1'b1;
        end else if (last) begin
            q_out   <= q_final;
            rem_out <= rem_final;
            dbz_out <= 1'b0;
        end
    end

    assign bus.busy        = (state == CALC);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = q_out;
    assign bus.remainder   = rem_out;
    assign bus.div_by_zero = dbz_out;

endmodule

// File: tb/tb_fixed_point_divider_seq.sv
// Directed self-checking bench for fixed_point_divider_seq (DW=8, VW=4, FRAC=4).
module tb_fixed_point_divider_seq;
    localparam int DW   = 8;
    localparam int VW   = 4;
    localparam int FRAC = 4;
    localparam int QW   = 12;
`ifdef FXDIV_ROUND_EN
    localparam int NITER = QW + 1;
    localparam int Q_2_3 = 'h00B;
    localparam int Q_3_7 = 'h007;
`else
    localparam int NITER = QW;
    localparam int Q_2_3 = 'h00A;
    localparam int Q_3_7 = 'h006;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fixed_point_divider_seq_if #(.DW(DW), .VW(VW), .FRAC(FRAC)) bus ();

    fixed_point_divider_seq #(.DW(DW), .VW(VW), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input int dd, input int dv);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = DW'(dd);
        bus.divisor  = VW'(dv);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called 1ns after the accepting edge; k = edges after accept until done is seen.
    task automatic wait_done(output int k, output int nb, output int unstable);
        logic [QW-1:0] q0;
        q0 = bus.quotient;
        k = 0;
        nb = 0;
        unstable = 0;
        while (!bus.done && k < 40) begin
            if (bus.busy) nb++;
            if (bus.quotient !== q0) unstable++;
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic op(input string tag, input int dd, input int dv, input int eq,
                      input int er, input int edbz, input int elat);
        int k, nb, un;
        launch(dd, dv);
        wait_done(k, nb, un);
        chk({tag, ".lat"}, k, elat);
        chk({tag, ".q"}, int'(bus.quotient), eq);
        chk({tag, ".rem"}, int'(bus.remainder), er);
        chk({tag, ".dbz"}, int'(bus.div_by_zero), edbz);
        chk({tag, ".busy"}, nb, elat);
        chk({tag, ".stable"}, un, 0);
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, int'(bus.done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, nb, un, nd, qd, rd;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", int'(bus.busy), 0);
        chk("rst.done", int'(bus.done), 0);
        chk("rst.q", int'(bus.quotient), 0);
        chk("rst.rem", int'(bus.remainder), 0);
        chk("rst.dbz", int'(bus.div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        op("d10_4", 10, 4, 'h028, 0, 0, NITER);
        op("d7_3", 7, 3, 'h025, 1, 0, NITER);
        op("d255_1", 255, 1, 'hFF0, 0, 0, NITER);
        op("d2_3", 2, 3, Q_2_3, 2, 0, NITER);
        op("d3_7", 3, 7, Q_3_7, 6, 0, NITER);
        op("d255_15", 255, 15, 'h110, 0, 0, NITER);
        op("d0_5", 0, 5, 0, 0, 0, NITER);
        op("dbz", 5, 0, 'hFFF, 0, 1, 0);

        // Reset in the middle of an operation: outputs clear at once, no done appears.
        launch(7, 3);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst.q", int'(bus.quotient), 0);
        chk("mid_rst.rem", int'(bus.remainder), 0);
        chk("mid_rst.dbz", int'(bus.div_by_zero), 0);
        chk("mid_rst.busy", int'(bus.busy), 0);
        chk("mid_rst.done", int'(bus.done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (NITER + 4) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
        end
        chk("mid_rst.nodone", nd, 0);
        op("after_rst", 10, 4, 'h028, 0, 0, NITER);

        // A start pulse while busy must be ignored, operands not re-captured.
        launch(255, 1);
        nd = 0;
        qd = 0;
        rd = 0;
        for (int i = 0; i < NITER + 6; i++) begin
            if (bus.done) begin
                nd++;
                qd = int'(bus.quotient);
                rd = int'(bus.remainder);
            end
            if (i == 5) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd7;
                bus.divisor  = 4'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        chk("ignore.ndone", nd, 1);
        chk("ignore.q", qd, 'hFF0);
        chk("ignore.rem", rd, 0);

        // Back-to-back: start raised during the done cycle is accepted without a bubble.
        launch(7, 3);
        wait_done(k, nb, un);
        chk("b2b.lat1", k, NITER);
        chk("b2b.q1", int'(bus.quotient), 'h025);
        bus.start    = 1'b1;
        bus.dividend = 8'd10;
        bus.divisor  = 4'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b.busy_after", int'(bus.busy), 1);
        wait_done(k, nb, un);
        chk("b2b.lat2", k, NITER);
        chk("b2b.q2", int'(bus.quotient), 'h028);
        chk("b2b.rem2", int'(bus.remainder), 0);
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 4'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b.dbz_done", int'(bus.done), 1);
        chk("b2b.dbz_q", int'(bus.quotient), 'hFFF);
        chk("b2b.dbz_flag", int'(bus.div_by_zero), 1);
        @(posedge clk);
        #1;
        chk("b2b.idle", int'(bus.done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
